// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder, WIDTH split into BLK-bit blocks, BLK_PER_STG blocks per stage; optional subtract via CSA_SUB_EN.
// Latency STAGES cycles; one result per cycle. Global stall: every stage advances only when o_valid=0 or i_ready=1.
module csa_pipe_adder #(
  parameter int WIDTH       = 64,
  parameter int BLK         = 4,
  parameter int BLK_PER_STG = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_cin,
`ifdef CSA_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int NBLK   = (WIDTH + BLK - 1) / BLK;
  localparam int STAGES = (NBLK + BLK_PER_STG - 1) / BLK_PER_STG;

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic [STAGES-1:0] c_q, c_d, vld_q, vld_d;

  // Stage-input view: entry 0 is the primary input, entry s+1 is register stage s.
  logic [WIDTH-1:0] a_p   [STAGES+1];
  logic [WIDTH-1:0] b_p   [STAGES+1];
  logic [WIDTH-1:0] sum_p [STAGES+1];
  logic [STAGES:0]  c_p, vld_p;

  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             adv;

  logic [WIDTH-1:0] a_t, b_t, s_t;
  logic             c_t, c0, c1;
  logic [BLK-1:0]   t0, t1;

  always_comb begin
    b_in   = i_add_term2;
    cin_in = i_cin;
`ifdef CSA_SUB_EN
    if (i_sub) begin
      b_in   = ~i_add_term2;
      cin_in = 1'b1;
    end
`endif
  end

  always_comb begin
    a_p[0]   = i_add_term1;
    b_p[0]   = b_in;
    sum_p[0] = '0;
    c_p[0]   = cin_in;
    vld_p[0] = i_valid;
    for (int s = 0; s < STAGES; s++) begin
      a_p[s+1]   = a_q[s];
      b_p[s+1]   = b_q[s];
      sum_p[s+1] = sum_q[s];
      c_p[s+1]   = c_q[s];
      vld_p[s+1] = vld_q[s];
    end
  end

  always_comb begin
    a_t = '0;
    b_t = '0;
    s_t = '0;
    c_t = 1'b0;
    c0  = 1'b0;
    c1  = 1'b0;
    t0  = '0;
    t1  = '0;
    for (int s = 0; s < STAGES; s++) begin
      a_t = a_p[s];
      b_t = b_p[s];
      s_t = sum_p[s];
      c_t = c_p[s];
      for (int k = 0; k < BLK_PER_STG; k++) begin
        // Block 0 ripples with the true carry-in; others precompute both carries.
        if (s * BLK_PER_STG + k == 0) begin
          c0 = c_t;
          c1 = c_t;
        end else begin
          c0 = 1'b0;
          c1 = 1'b1;
        end
        t0 = '0;
        t1 = '0;
        for (int j = 0; j < BLK; j++) begin
          if ((s * BLK_PER_STG + k) < NBLK && ((s * BLK_PER_STG + k) * BLK + j) < WIDTH) begin
            t0[j] = a_t[(s * BLK_PER_STG + k) * BLK + j] ^ b_t[(s * BLK_PER_STG + k) * BLK + j] ^ c0;
            c0    = (a_t[(s * BLK_PER_STG + k) * BLK + j] & b_t[(s * BLK_PER_STG + k) * BLK + j]) |
                    (c0 & (a_t[(s * BLK_PER_STG + k) * BLK + j] ^ b_t[(s * BLK_PER_STG + k) * BLK + j]));
            t1[j] = a_t[(s * BLK_PER_STG + k) * BLK + j] ^ b_t[(s * BLK_PER_STG + k) * BLK + j] ^ c1;
            c1    = (a_t[(s * BLK_PER_STG + k) * BLK + j] & b_t[(s * BLK_PER_STG + k) * BLK + j]) |
                    (c1 & (a_t[(s * BLK_PER_STG + k) * BLK + j] ^ b_t[(s * BLK_PER_STG + k) * BLK + j]));
            s_t[(s * BLK_PER_STG + k) * BLK + j] = c_t ? t1[j] : t0[j];
          end
        end
        if ((s * BLK_PER_STG + k) < NBLK) begin
          c_t = c_t ? c1 : c0;
        end
      end
      // The last stage has no upper operand bits left to carry forward.
      a_d[s]   = (s == STAGES - 1) ? '0 : a_t;
      b_d[s]   = (s == STAGES - 1) ? '0 : b_t;
      sum_d[s] = s_t;
      c_d[s]   = c_t;
      vld_d[s] = vld_p[s];
    end
  end

  assign o_valid = vld_p[STAGES];
  assign o_sum   = sum_p[STAGES];
  assign o_cout  = c_p[STAGES];
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
      end
      c_q   <= '0;
      vld_q <= '0;
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        sum_q[s] <= sum_d[s];
      end
      c_q   <= c_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder at WIDTH=42, BLK=4, BLK_PER_STG=4 (three stages); subtract cases when CSA_SUB_EN is defined.
module tb_csa_pipe_adder;
  localparam int W = 42;

  logic         clk;
  logic         rst_n;
  logic         i_valid, o_ready, i_cin, o_valid, i_ready, o_cout, i_sub;
  logic [W-1:0] a, b, o_sum;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;
  vec_t tbl[8];

  csa_pipe_adder #(.WIDTH(W), .BLK(4), .BLK_PER_STG(4)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_add_term1(a),
    .i_add_term2(b),
    .i_cin(i_cin),
`ifdef CSA_SUB_EN
    .i_sub(i_sub),
`endif
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sum(o_sum),
    .o_cout(o_cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc, input logic ms);
    if (ms) return {1'b0, ma} + {1'b0, ~mb} + {{W{1'b0}}, 1'b1};
    return {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h want none", {o_cout, o_sum});
      end else begin
        check("result", 64'({o_cout, o_sum}), 64'(exp_q.pop_front()));
      end
      n_out++;
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic ts, input logic [W:0] e, input logic rdy);
    i_valid = v;
    a       = ta;
    b       = tb_;
    i_cin   = tc;
    i_sub   = ts;
    i_ready = rdy;
    @(negedge clk);
    if (v && o_ready) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] held, ra, rb;
    logic         rc, rs, rv, rr;
    int           lat, base;

    tbl[0] = '{42'h3FF_FFFF_FFFF, 42'd1,             1'b0, 42'd0,             1'b1};
    tbl[1] = '{42'd0,             42'd0,             1'b0, 42'd0,             1'b0};
    tbl[2] = '{42'd0,             42'd0,             1'b1, 42'd1,             1'b0};
    tbl[3] = '{42'h3FF_FFFF_FFFF, 42'h3FF_FFFF_FFFF, 1'b1, 42'h3FF_FFFF_FFFF, 1'b1};
    tbl[4] = '{42'h155_5555_5555, 42'h2AA_AAAA_AAAA, 1'b0, 42'h3FF_FFFF_FFFF, 1'b0};
    tbl[5] = '{42'h155_5555_5555, 42'h2AA_AAAA_AAAA, 1'b1, 42'd0,             1'b1};
    tbl[6] = '{42'h000_0000_FFFF, 42'd1,             1'b0, 42'h000_0001_0000, 1'b0};
    tbl[7] = '{42'h200_0000_0000, 42'h200_0000_0000, 1'b0, 42'd0,             1'b1};

    rst_n = 1'b0; i_valid = 1'b0; a = '0; b = '0; i_cin = 1'b0; i_sub = 1'b0; i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_sum",   64'(o_sum),   64'd0);
    check("rst_cout",  64'(o_cout),  64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 64'(o_valid), 64'd0);

    foreach (tbl[i]) drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, {tbl[i].cout, tbl[i].sum}, 1'b1);
    idle(5);

    // Full-length carry chain: result must appear exactly three edges after acceptance.
    drive(1'b1, 42'h3FF_FFFF_FFFF, 42'd1, 1'b0, 1'b0, {1'b1, 42'd0}, 1'b1);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd3);
    idle(4);

    for (int k = 0; k < 100; k++) begin
      drive(1'b1, W'(k), W'(3 * k), 1'b0, 1'b0, (W+1)'(4 * k), 1'b1);
      check("stream_ready", 64'(o_ready), 64'd1);
      if (k >= 2) check("stream_valid", 64'(o_valid), 64'd1);
    end
    idle(5);
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    base = n_out;
    for (int k = 0; k < 3; k++)
      drive(1'b1, W'(100 + k), W'(7 * k), 1'b1, 1'b0, model(W'(100 + k), W'(7 * k), 1'b1, 1'b0), 1'b0);
    held = o_sum;
    check("bp_head", 64'({o_valid, held}), 64'({1'b1, model(W'(100), W'(0), 1'b1, 1'b0)}) & 64'h7FF_FFFF_FFFF | (64'(1) << W));
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, W'(103), W'(21), 1'b1, 1'b0, model(W'(103), W'(21), 1'b1, 1'b0), 1'b0);
      check("bp_ready", 64'(o_ready), 64'd0);
      check("bp_hold",  64'(o_sum),   64'(held));
    end
    for (int k = 3; k < 10; k++)
      drive(1'b1, W'(100 + k), W'(7 * k), 1'b1, 1'b0, model(W'(100 + k), W'(7 * k), 1'b1, 1'b0), 1'b1);
    idle(6);
    check("bp_count", 64'(n_out - base), 64'd10);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

`ifdef CSA_SUB_EN
    drive(1'b1, 42'd5, 42'd7, 1'b0, 1'b1, {1'b0, 42'h3FF_FFFF_FFFE}, 1'b1);
    drive(1'b1, 42'd7, 42'd5, 1'b1, 1'b1, {1'b1, 42'd2}, 1'b1);
    idle(5);
`endif

    for (int n = 0; n < 3000; n++) begin
      ra = rnd();
      rb = rnd();
      rc = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
`ifdef CSA_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      drive(rv, ra, rb, rc, rs, model(ra, rb, rc, rs), rr);
    end
    idle(6);
    check("random_drained", 64'(exp_q.size()), 64'd0);

    for (int k = 1; k <= 3; k++) drive(1'b1, W'(k), W'(3 * k), 1'b0, 1'b0, (W+1)'(4 * k), 1'b1);
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_sum",   64'(o_sum),   64'd0);
    check("midrst_cout",  64'(o_cout),  64'd0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_release_valid", 64'(o_valid), 64'd0);
    idle(6);
    check("midrst_no_stale", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
